// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential prefetch into a DEPTH-entry reservation queue
// feeding IF/ID, with EX-stage redirect flush and discard of stale in-flight responses.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    input  logic        id_ready,
    output logic        drain_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic        alloc;
        logic        filled;
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    slot_t            slots [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [CNT_W-1:0] alloc_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_cnt_next;
    logic [CNT_W-1:0] unfilled_cnt;
    logic [SUM_W-1:0] drop_sum;
    logic [31:0]      fetch_pc;
    state_t           state;
    state_t           state_next;

    logic cap_ok;
    logic req_fire;
    logic rsp_drop;
    logic rsp_fill;
    logic pop;

    // Requests still owed a response that belong to the live queue.
    always_comb begin
        unfilled_cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (slots[PTR_W'(i)].alloc && !slots[PTR_W'(i)].filled) begin
                unfilled_cnt = unfilled_cnt + CNT_W'(1);
            end
        end
    end

    // Stale responses share the in-flight budget with live slots.
    assign cap_ok         = (SUM_W'(alloc_cnt) + SUM_W'(drop_cnt)) < SUM_W'(DEPTH);
    assign imem_req_valid = rst & ~redirect_valid & cap_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid
                    & slots[fill_ptr].alloc & ~slots[fill_ptr].filled;

    always_comb begin
        id_valid = slots[head_ptr].alloc & slots[head_ptr].filled;
        id_pc    = 32'h0;
        id_instr = NOP_INSTR;
        if (id_valid) begin
            id_pc    = slots[head_ptr].pc;
            id_instr = slots[head_ptr].instr;
        end
    end

    assign id_pc_plus4 = id_pc + 32'd4;
    assign pop         = id_valid & id_ready & ~redirect_valid;

    // On redirect every unfilled slot turns into a response to throw away.
    always_comb begin
        drop_sum      = SUM_W'(drop_cnt) + SUM_W'(unfilled_cnt);
        drop_cnt_next = drop_cnt;
        if (redirect_valid) begin
            if (imem_rsp_valid && (drop_sum != '0)) begin
                drop_cnt_next = CNT_W'(drop_sum - SUM_W'(1));
            end else begin
                drop_cnt_next = CNT_W'(drop_sum);
            end
        end else if (rsp_drop) begin
            drop_cnt_next = drop_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (drop_cnt_next != '0) state_next = DRAIN;
            DRAIN:   if (drop_cnt_next == '0) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        drain_busy = 1'b0;
        if (state == DRAIN) begin
            drain_busy = 1'b1;
        end
    end

    // Queue, pointers and fetch address; redirect overrides pop, fill and issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots[PTR_W'(i)] <= '0;
            end
            head_ptr  <= '0;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            alloc_cnt <= '0;
            drop_cnt  <= '0;
            fetch_pc  <= RESET_PC;
        end else begin
            drop_cnt <= drop_cnt_next;
            if (redirect_valid) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    slots[PTR_W'(i)].alloc  <= 1'b0;
                    slots[PTR_W'(i)].filled <= 1'b0;
                end
                head_ptr  <= '0;
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                alloc_cnt <= '0;
                fetch_pc  <= redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (req_fire) begin
                    slots[alloc_ptr].alloc  <= 1'b1;
                    slots[alloc_ptr].filled <= 1'b0;
                    slots[alloc_ptr].pc     <= fetch_pc;
                    alloc_ptr               <= alloc_ptr + PTR_W'(1);
                    fetch_pc                <= fetch_pc + 32'd4;
                end
                if (rsp_fill) begin
                    slots[fill_ptr].filled <= 1'b1;
                    slots[fill_ptr].instr  <= imem_rsp_data;
                    fill_ptr               <= fill_ptr + PTR_W'(1);
                end
                if (pop) begin
                    slots[head_ptr].alloc  <= 1'b0;
                    slots[head_ptr].filled <= 1'b0;
                    head_ptr               <= head_ptr + PTR_W'(1);
                end
                alloc_cnt <= alloc_cnt + CNT_W'(req_fire) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register of the pipelined RV32 core. It generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel with in-order, variable-latency responses, and buffers fetched words in a DEPTH-entry reservation queue. The queue head is presented to the decode stage as {pc, instr, pc+4}. An EX-stage redirect (taken branch, jal, jalr) flushes the queue and discards stale in-flight responses.

## Interface
- DEPTH, 4, queue and in-flight capacity; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value driven on id_instr when id_valid=0
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- redirect_valid  in  1  EX stage requests a fetch redirect this cycle
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 00
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, word-aligned
- imem_req_ready  in  1  memory accepts the request
- imem_rsp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- id_valid  out  1  queue head holds a filled instruction
- id_pc  out  32  PC of the head instruction
- id_instr  out  32  head instruction word
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32
- id_ready  in  1  decode stage consumes the head; driven low by a hazard stall
- drain_busy  out  1  high while the FSM is in DRAIN

## Operation
- State: fetch_pc; circular queue of DEPTH slots, each holding {pc, instr, filled}; head, alloc and fill pointers; alloc_cnt in 0..DEPTH; drop_cnt in 0..DEPTH; FSM with states RUN and DRAIN.
- Request issue:
  - imem_req_valid = rst & ~redirect_valid & (alloc_cnt + drop_cnt < DEPTH).
  - imem_req_addr = fetch_pc.
  - On acceptance (valid & ready): allocate the slot at the alloc pointer with pc = fetch_pc and filled = 0, then fetch_pc += 4, wrapping 0xFFFF_FFFC to 0.
  - An unaccepted request may be withdrawn; the memory must not latch it.
- Response handling:
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise, the slot at the fill pointer takes instr = imem_rsp_data and filled = 1, and the fill pointer advances.
  - A response with no allocated unfilled slot and drop_cnt = 0 is a protocol error and is ignored.
- Output:
  - id_valid = head slot is allocated and filled.
  - When id_valid = 0: id_instr = NOP_INSTR and id_pc = 0.
  - Pop on id_valid & id_ready: free the head slot and advance the head pointer.
- Redirect (redirect_valid = 1) takes priority over pop, fill and issue in the same cycle:
  - All slots are freed and all pointers reset to 0.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt_next = drop_cnt + (allocated-unfilled slots) − imem_rsp_valid.
  - A response arriving in the redirect cycle is always discarded.
- FSM:
  - RUN → DRAIN when drop_cnt_next > 0.
  - DRAIN → RUN when drop_cnt_next = 0.
  - Requests to the new target may issue during DRAIN, bounded by the capacity rule.
- Simultaneous events:
  - Allocate and pop in the same cycle: alloc_cnt unchanged.
  - Fill and pop in the same cycle are legal; only a filled head may pop.
  - A second redirect during DRAIN accumulates into drop_cnt; the capacity rule guarantees drop_cnt ≤ DEPTH.

## Timing
- Reset values: fetch_pc = RESET_PC, queue empty, alloc_cnt = drop_cnt = 0, FSM = RUN, id_valid = 0, id_instr = NOP_INSTR, id_pc = 0, id_pc_plus4 = 4, imem_req_valid = 0 while rst = 0, drain_busy = 0.
- Reset asserted mid-operation clears all state immediately; in-flight responses after release are the memory's responsibility (memory is reset together with this block).
- Cycle-level latencies:
  - imem_req_valid is combinational on state and redirect_valid; it rises in the first cycle after rst deasserts.
  - A response accepted in cycle t makes id_valid high in cycle t+1.
  - Redirect in cycle t: first target request in t+1; with 1-cycle memory, response in t+2, id_valid in t+3.
- Throughput: with 1-cycle memory and id_ready held high, one instruction per cycle in steady state.

## Test plan
- Reset then run with 1-cycle memory, id_ready = 1: requests 0x0, 0x4, 0x8…; id_valid from cycle 3; id_pc increments by 4 each cycle; id_pc_plus4 = id_pc + 4.
- Hold id_ready = 0 for 10 cycles: exactly DEPTH = 4 requests issue, then imem_req_valid = 0; on release, 0x0..0xC pop in order with no loss or duplication.
- Memory latency 3 with 2 outstanding requests, then redirect_pc = 0x100: drop_cnt = 2, drain_busy high until both stale words are discarded; first id_pc after the redirect is 0x100.
- Redirect in the same cycle as an imem_rsp_valid and an id_ready pop: that response is discarded, no pop is counted, and the next id_pc = redirect target.
- RESET_PC = 0xFFFF_FFF8: fetch sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; id_pc_plus4 for 0xFFFF_FFFC is 0x0.
- Assert rst low mid-stream with 3 slots filled: id_valid = 0, id_instr = 0x13 asynchronously; after release, fetch restarts at RESET_PC.
